// File: rtl/link_tx_if.sv
// Flit handshake bundle for link_tx: the local FWFT fifo read side plus the
// downstream link (push side and returned credit pulse).
interface link_tx_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_pop;
  logic                  link_valid;
  logic [DATA_WIDTH-1:0] link_data;
  logic                  credit_in;

  modport master (
    input  fifo_empty, fifo_dout, credit_in,
    output fifo_pop, link_valid, link_data
  );

  modport slave (
    output fifo_empty, fifo_dout, credit_in,
    input  fifo_pop, link_valid, link_data
  );
endinterface

// File: rtl/link_tx.sv
// Output-side link transmitter: drains the port fifo onto the inter-router
// link under credit flow control, starting new packets only when granted.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | at a packet boundary; a flit is sent only with grant_i
// S_IN_PKT | wormhole packet open; flits flow regardless of grant_i
module link_tx #(
  parameter int DATA_WIDTH = 64,
  parameter int CREDITS    = 8,
  parameter int CNT_WIDTH  = $clog2(CREDITS + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 grant_i,
  link_tx_if.master            bus,
  output logic [CNT_WIDTH-1:0] credit_count_o,
  output logic                 busy_o,
  output logic                 credit_err_o
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_IN_PKT = 1'b1
  } state_e;

  localparam logic [1:0] FT_HEAD   = 2'b10;
  localparam logic [1:0] FT_TAIL   = 2'b01;
  localparam logic [CNT_WIDTH-1:0] CREDITS_C = CNT_WIDTH'(CREDITS);
  localparam logic [CNT_WIDTH-1:0] ONE_C     = CNT_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    credit_q, credit_d;
  logic                    err_q, err_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    fire;
  logic [1:0]              ftype;

  assign ftype = bus.fifo_dout[DATA_WIDTH-1 -: 2];
  assign fire  = !bus.fifo_empty && (credit_q != '0) &&
                 ((state_q == S_IN_PKT) || grant_i);

  // Gate with reset so no pop escapes while the block is held in reset.
  assign bus.fifo_pop   = fire && reset_i;
  assign bus.link_valid = valid_q;
  assign bus.link_data  = data_q;
  assign credit_count_o = credit_q;
  assign busy_o         = (state_q == S_IN_PKT);
  assign credit_err_o   = err_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= S_IDLE;
      credit_q <= CREDITS_C;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    err_d    = err_q;
    valid_d  = 1'b0;
    data_d   = data_q;

    if (fire) begin
      valid_d = 1'b1;
      data_d  = bus.fifo_dout;
      // Stray body/tail in S_IDLE and stray head in S_IN_PKT pass through.
      case (state_q)
        S_IDLE:   if (ftype == FT_HEAD) state_d = S_IN_PKT;
        S_IN_PKT: if (ftype == FT_TAIL) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end

    case ({fire, bus.credit_in})
      2'b10: credit_d = credit_q - ONE_C;
      2'b01: begin
        if (credit_q == CREDITS_C) err_d = 1'b1;
        else                       credit_d = credit_q + ONE_C;
      end
      default: credit_d = credit_q;
    endcase
  end

endmodule

// File: tb/tb_link_tx.sv
// Directed bench for link_tx: a cycle-by-cycle vector table plus hand-written
// sequences for reset, credit exhaustion and reset in the middle of a packet.
module tb_link_tx;

  localparam int DW = 64;

  logic       clk;
  logic       reset;
  logic       grant;
  logic [3:0] credit_count;
  logic       busy;
  logic       credit_err;

  int n_checks = 0;
  int n_errors = 0;

  link_tx_if #(.DATA_WIDTH(DW)) bus ();

  link_tx #(.DATA_WIDTH(DW), .CREDITS(8)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .grant_i        (grant),
    .bus            (bus),
    .credit_count_o (credit_count),
    .busy_o         (busy),
    .credit_err_o   (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          empty;
    logic [DW-1:0] dout;
    logic          grant;
    logic          ci;
    logic          pop;
    logic          lv;
    logic [DW-1:0] ld;
    logic [3:0]    cnt;
    logic          busy;
    logic          err;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  localparam logic [DW-1:0] F_SGL  = 64'hC000_0000_0000_00AA;
  localparam logic [DW-1:0] F_H1   = 64'h8000_0000_0000_0001;
  localparam logic [DW-1:0] F_B2   = 64'h0000_0000_0000_0002;
  localparam logic [DW-1:0] F_T3   = 64'h4000_0000_0000_0003;
  localparam logic [DW-1:0] F_B4   = 64'h0000_0000_0000_0004;
  localparam logic [DW-1:0] F_H5   = 64'h8000_0000_0000_0005;
  localparam logic [DW-1:0] F_H6   = 64'h8000_0000_0000_0006;
  localparam logic [DW-1:0] F_T7   = 64'h4000_0000_0000_0007;
  localparam logic [DW-1:0] F_SGL2 = 64'hC000_0000_0000_00BB;
  localparam logic [DW-1:0] F_BODY = 64'h0000_0000_0000_0B0D;

  function automatic vec_t mk(input logic e, input logic [DW-1:0] d, input logic g,
                              input logic c, input logic p, input logic v,
                              input logic [DW-1:0] ld, input logic [3:0] n,
                              input logic b, input logic er);
    vec_t r;
    r.empty = e; r.dout = d; r.grant = g; r.ci = c;
    r.pop = p; r.lv = v; r.ld = ld; r.cnt = n; r.busy = b; r.err = er;
    return r;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic e, input logic [DW-1:0] d, input logic g, input logic c);
    bus.fifo_empty = e;
    bus.fifo_dout  = d;
    grant          = g;
    bus.credit_in  = c;
  endtask

  task automatic chk_regs(input string tag, input logic v, input logic [DW-1:0] ld,
                          input logic [3:0] n, input logic b, input logic er);
    chk({tag, ".link_valid"},   DW'(bus.link_valid), DW'(v));
    chk({tag, ".link_data"},    bus.link_data,       ld);
    chk({tag, ".credit_count"}, DW'(credit_count),   DW'(n));
    chk({tag, ".busy"},         DW'(busy),           DW'(b));
    chk({tag, ".credit_err"},   DW'(credit_err),     DW'(er));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, '0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int n_pop, n_lv;

    tbl[0]  = mk(1, '0,     0, 0,  0, 0, '0,    4'd8, 0, 0);
    tbl[1]  = mk(0, F_SGL,  1, 0,  1, 1, F_SGL, 4'd7, 0, 0);
    tbl[2]  = mk(1, '0,     0, 0,  0, 0, F_SGL, 4'd7, 0, 0);
    tbl[3]  = mk(0, F_H1,   1, 0,  1, 1, F_H1,  4'd6, 1, 0);
    tbl[4]  = mk(0, F_B2,   0, 0,  1, 1, F_B2,  4'd5, 1, 0);
    tbl[5]  = mk(0, F_T3,   0, 0,  1, 1, F_T3,  4'd4, 0, 0);
    tbl[6]  = mk(0, F_B4,   0, 1,  0, 0, F_T3,  4'd5, 0, 0);
    tbl[7]  = mk(0, F_B4,   1, 0,  1, 1, F_B4,  4'd4, 0, 0);
    tbl[8]  = mk(0, F_H5,   1, 1,  1, 1, F_H5,  4'd4, 1, 0);
    tbl[9]  = mk(0, F_H6,   0, 0,  1, 1, F_H6,  4'd3, 1, 0);
    tbl[10] = mk(1, '0,     0, 1,  0, 0, F_H6,  4'd4, 1, 0);
    tbl[11] = mk(0, F_T7,   0, 1,  1, 1, F_T7,  4'd4, 0, 0);
    tbl[12] = mk(1, '0,     0, 1,  0, 0, F_T7,  4'd5, 0, 0);
    tbl[13] = mk(1, '0,     0, 1,  0, 0, F_T7,  4'd6, 0, 0);
    tbl[14] = mk(1, '0,     0, 1,  0, 0, F_T7,  4'd7, 0, 0);
    tbl[15] = mk(1, '0,     0, 1,  0, 0, F_T7,  4'd8, 0, 0);
    tbl[16] = mk(1, '0,     0, 1,  0, 0, F_T7,  4'd8, 0, 1);
    tbl[17] = mk(1, '0,     1, 0,  0, 0, F_T7,  4'd8, 0, 1);
    tbl[18] = mk(0, F_SGL2, 1, 1,  1, 1, F_SGL2, 4'd8, 0, 1);

    // Reset held with a granted, non-empty fifo: nothing may move.
    reset = 1'b0;
    drive(1'b0, F_SGL, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.fifo_pop", DW'(bus.fifo_pop), '0);
    chk_regs("rst", 1'b0, '0, 4'd8, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rel.fifo_pop", DW'(bus.fifo_pop), '0);
    chk_regs("rel", 1'b0, '0, 4'd8, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].empty, tbl[i].dout, tbl[i].grant, tbl[i].ci);
      #1;
      chk($sformatf("vec%0d.fifo_pop", i), DW'(bus.fifo_pop), DW'(tbl[i].pop));
      @(posedge clk);
      #1;
      chk_regs($sformatf("vec%0d", i), tbl[i].lv, tbl[i].ld, tbl[i].cnt, tbl[i].busy, tbl[i].err);
    end

    // Sticky error clears only through reset.
    do_reset();
    #1;
    chk("clr.credit_err", DW'(credit_err), '0);

    // Credit exhaustion: head then a long run of bodies, no credits returned.
    n_pop = 0;
    n_lv  = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(1'b0, (i == 0) ? F_H1 : F_BODY, (i == 0), 1'b0);
      #1;
      if (bus.fifo_pop) n_pop++;
      @(posedge clk);
      #1;
      if (bus.link_valid) n_lv++;
    end
    chk("exh.pops",  DW'(n_pop), DW'(8));
    chk("exh.sent",  DW'(n_lv),  DW'(8));
    chk("exh.count", DW'(credit_count), DW'(0));
    chk("exh.busy",  DW'(busy), DW'(1));

    @(negedge clk);
    drive(1'b0, F_BODY, 1'b0, 1'b1);
    #1;
    chk("cz.same_cycle_pop", DW'(bus.fifo_pop), '0);
    @(posedge clk);
    #1;
    chk("cz.count_up", DW'(credit_count), DW'(1));
    chk("cz.no_valid", DW'(bus.link_valid), '0);
    @(negedge clk);
    drive(1'b0, F_BODY, 1'b0, 1'b0);
    #1;
    chk("cz.next_pop", DW'(bus.fifo_pop), DW'(1));
    @(posedge clk);
    #1;
    chk_regs("cz.sent", 1'b1, F_BODY, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    chk("cz.stall_pop", DW'(bus.fifo_pop), '0);

    // Asynchronous reset mid-packet abandons it; the next flit needs grant.
    drive(1'b0, F_BODY, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    chk("mid.fifo_pop", DW'(bus.fifo_pop), '0);
    chk_regs("mid", 1'b0, '0, 4'd8, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, F_BODY, 1'b0, 1'b0);
    #1;
    chk("post.nogrant_pop", DW'(bus.fifo_pop), '0);
    @(posedge clk);
    #1;
    chk_regs("post.idle", 1'b0, '0, 4'd8, 1'b0, 1'b0);
    @(negedge clk);
    grant = 1'b1;
    #1;
    chk("post.grant_pop", DW'(bus.fifo_pop), DW'(1));
    @(posedge clk);
    #1;
    chk_regs("post.body", 1'b1, F_BODY, 4'd7, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/link_tx.md
Name: link_tx

Overview:
- Output-side link transmitter for one router port.
- Reads flits from the port's first-word-fall-through fifo (the fifo's pop/empty/dout side) and drives them onto an inter-router link.
- The link feeds the downstream router's input fifo push side, under credit-based flow control.
- Enforces wormhole packet atomicity: the switch-allocator grant is honoured only at packet boundaries.

Parameters:
- DATA_WIDTH, 64, flit width in bits; bits [DATA_WIDTH-1:DATA_WIDTH-2] carry the flit type.
- CREDITS, 8, downstream fifo depth (2**ADDR_WIDTH of the downstream fifo); initial credit count.
- CNT_WIDTH, $clog2(CREDITS+1), width of the credit counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- fifo_empty  input  1  local fifo empty flag.
- fifo_dout  input  DATA_WIDTH  local fifo head flit; valid whenever fifo_empty=0.
- fifo_pop  output  1  pops the local fifo head at the next rising edge.
- grant  input  1  switch allocator permits starting a new packet.
- link_valid  output  1  link_data holds a flit this cycle; drives the downstream fifo push.
- link_data  output  DATA_WIDTH  transmitted flit; drives the downstream fifo din.
- credit_in  input  1  one-cycle pulse; downstream popped one flit.
- credit_count  output  CNT_WIDTH  current available credits.
- busy  output  1  high while a packet is in progress (state IN_PKT).
- credit_err  output  1  sticky; set when a credit is returned while credit_count==CREDITS.

Behaviour:
- Flit types, top two bits: 2'b10 head, 2'b00 body, 2'b01 tail, 2'b11 single-flit packet.
- States: IDLE, IN_PKT. busy = (state==IN_PKT).
- fire = !fifo_empty && credit_count!=0 && (state==IN_PKT || grant). This is combinational.
- fifo_pop = fire, combinational. No pop is issued when fifo_empty=1.
- Transitions, evaluated on fire only:
  - IDLE: head -> IN_PKT; single -> stay IDLE.
  - IN_PKT: tail -> IDLE; body -> stay IN_PKT.
  - Body or tail seen in IDLE: sent anyway, no state change.
  - Head seen in IN_PKT: sent, stays IN_PKT.
- grant is ignored in IN_PKT. Dropping grant mid-packet does not stall the packet.
- Output register: on fire, link_valid<=1 and link_data<=fifo_dout. Otherwise link_valid<=0 and link_data holds its previous value.
- Latency is one cycle, from the fire cycle to link_valid. Throughput is one flit per cycle while credits remain.
- Credit counter, per cycle:
  - fire only: -1.
  - credit_in only: +1.
  - both: unchanged.
- Credit overflow: credit_in with credit_count==CREDITS and no fire -> count holds at CREDITS, credit_err<=1.
- Credit underflow is impossible, because fire requires credit_count!=0.
- Credit at zero: credit_in when credit_count==0 makes fire possible from the following cycle. A credit returned this cycle is not usable this cycle.
- Reset (reset=0, asynchronous) forces:
  - credit_count=CREDITS, state IDLE;
  - link_valid=0, link_data=0, credit_err=0.
  - Reset mid-packet abandons the packet. The next flit is treated per the IDLE rules.
- fifo_pop is 0 while reset is asserted.

Test Plan:
- Reset: assert reset=0 -> link_valid=0, link_data=0, credit_count=8, busy=0, credit_err=0, fifo_pop=0. Release -> values hold with an empty fifo.
- Single-flit packet: fifo holds 64'hC000_0000_0000_00AA (type 11), grant=1 -> fifo_pop=1 in cycle N; link_valid=1 with that data in N+1; credit_count=7; busy stays 0.
- Wormhole atomicity: head, body, tail queued; grant=1 for one cycle only -> all three flits sent on consecutive cycles; busy=1 from after the head until after the tail; credit_count=5.
- Credit exhaustion: CREDITS=8, 10 body flits in IN_PKT, no credit_in -> exactly 8 flits sent, then fifo_pop=0. One credit_in pulse -> exactly one more flit one cycle later.
- Simultaneous fire and credit_in with credit_count=4 -> count stays 4, flit transmitted.
- Overflow: credit_in with credit_count=8 and idle -> count stays 8, credit_err=1 and it stays 1 until reset.
